// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - start opcodes carried on the E-stage command bus
//   - md_sel read-select codes
//   - FSM state encoding
//   - helper that classifies an opcode as a multi-cycle launch
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] SEL_HI = 2'd1;
  localparam logic [1:0] SEL_LO = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  // Opcodes that occupy the unit for several cycles.
  function automatic logic is_md_launch(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Command/result bus between the E-stage control and the multiply/divide unit.
//   start/p1/p2/cancel : E-stage command and forwarded operands
//   md_sel             : HI/LO read select for md_out
//   d_md_use           : D-stage instruction touches HI/LO
//   busy/stall         : unit occupied / D-stage stall request
//   hi/lo/md_out       : architectural HI/LO and the selected read value
interface md_sequencer_if;
  logic [2:0]  start;
  logic [31:0] p1;
  logic [31:0] p2;
  logic        cancel;
  logic [1:0]  md_sel;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output start, p1, p2, cancel, md_sel, d_md_use,
    input  busy, stall, hi, lo, md_out
  );

  modport slave (
    input  start, p1, p2, cancel, md_sel, d_md_use,
    output busy, stall, hi, lo, md_out
  );
endinterface

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath.
//   op          : start opcode (mult/multu/div/divu are meaningful)
//   a, b        : rs / rt operands
//   res_hi      : product[63:32] or remainder
//   res_lo      : product[31:0]  or quotient
//   div_by_zero : divide opcode with b == 0 (result must not be committed)
module md_compute
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic        is_signed;
  logic        is_mult;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Signed division is done on magnitudes so that 0x80000000 / -1 never
  // overflows a signed divider; the quotient wraps back to 0x80000000.
  // NOTE: every output of a combinational block is assigned on all paths, otherwise a latch is inferred.
  always_comb begin
    is_signed   = (op == MD_MULT) || (op == MD_DIV);
    is_mult     = (op == MD_MULT) || (op == MD_MULTU);
    div_by_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

    // Low 64 bits of the product of sign/zero-extended operands are exact.
    a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = a_ext * b_ext;

    a_mag   = (is_signed && a[31]) ? (32'd0 - a) : a;
    b_mag   = (is_signed && b[31]) ? (32'd0 - b) : b;
    divisor = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;

    if (is_mult) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else begin
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      res_lo = (is_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
      res_hi = (is_signed && a[31])           ? (32'd0 - r_mag) : r_mag;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller owning HI/LO.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : md_sequencer_if.slave (command in, busy/stall/hi/lo/md_out out)
// A launch latches the result at once and holds busy for MULT_CYCLES or
// DIV_CYCLES; HI/LO update on the edge that ends busy.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic           clk,
  input  logic           reset,
  md_sequencer_if.slave  bus
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_dz;
  logic [31:0]      md_out_c;

  md_compute u_compute (
    .op          (bus.start),
    .a           (bus.p1),
    .b           (bus.p2),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (res_dz)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.cancel) begin
          if (is_md_launch(bus.start)) begin
            state_d   = S_BUSY;
            busy_d    = 1'b1;
            cnt_d     = ((bus.start == MD_MULT) || (bus.start == MD_MULTU)) ?
                        CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_dz_d = res_dz;
          end else if (bus.start == MD_MTHI) begin
            hi_d = bus.p1;
          end else if (bus.start == MD_MTLO) begin
            lo_d = bus.p1;
          end
        end
      end
      S_BUSY: begin
        // Commands and cancel are ignored here: the running op already
        // retired past E.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  always_comb begin
    case (bus.md_sel)
      SEL_HI:  md_out_c = hi_q;
      SEL_LO:  md_out_c = lo_q;
      default: md_out_c = 32'd0;
    endcase
  end

  // The launch term covers the cycle before busy rises.
  assign bus.stall  = bus.d_md_use & (busy_q | is_md_launch(bus.start));
  assign bus.busy   = busy_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.md_out = md_out_c;

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Multi-cycle multiply/divide controller that owns the HI/LO registers for the pipelined CPU. It sits beside the ALU in the E stage. It accepts mult/multu/div/divu/mthi/mtlo commands from the E-stage control word and models the unit's latency with a down-counter FSM. It commits results to HI/LO and raises the D-stage stall request for instructions that touch HI/LO while the unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; sampled at posedge clk, 0 = reset
start  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
p1  in  32  forwarded rs operand
p2  in  32  forwarded rt operand
cancel  in  1  flush of the E-stage instruction (exception/interrupt/eret); suppresses this cycle's start
md_sel  in  2  read select: 0 zero, 1 HI, 2 LO, 3 zero
d_md_use  in  1  D-stage instruction reads or writes HI/LO or launches an MD op
busy  out  1  registered; unit computing
stall  out  1  combinational D-stage stall request
hi  out  32  HI register
lo  out  32  LO register
md_out  out  32  combinational mux of hi/lo per md_sel

Behaviour:
- Reset (reset==0 at posedge): state IDLE, counter 0, hi=0, lo=0, pending regs 0, busy=0. Reset overrides everything, including mid-operation; an in-flight result is discarded.
- Accepted launch: state IDLE, start in {1..4}, cancel==0.
  - At that edge: pending_hi/pending_lo are computed from p1/p2 and latched.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES; state goes to BUSY.
- BUSY state:
  - busy=1 for exactly N cycles after the launch edge.
  - The counter decrements each edge.
  - On the edge where the counter reaches 0, hi/lo take the pending values and state returns to IDLE.
  - The new hi/lo are visible in the first cycle with busy=0.
- Arithmetic:
  - mult: signed 32x32, 64-bit product; hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - divu: unsigned.
  - div/divu with p2==0: the launch still occurs and busy runs for DIV_CYCLES, but hi/lo keep their previous values at commit.
  - Signed 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo, accepted only in IDLE with cancel==0: hi (or lo) = p1 at the next edge; no busy.
- Commands arriving while BUSY (protocol violation, normally prevented by stall): ignored; no state change.
- cancel==1: the start of that cycle is ignored. cancel never aborts an operation already in BUSY, because that instruction has already committed past E.
- stall = d_md_use & (busy | (start in {1..4})). This covers the launch cycle, before busy rises.
- Back-to-back: a launch may be accepted in the same cycle busy has just fallen (state IDLE).
- md_out is purely combinational from the current hi/lo. A read in the commit-visible cycle returns the new values.

Decomposition:
- Shared package md_pkg holds:
  - start opcode constants (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - md_sel constants (SEL_HI, SEL_LO);
  - FSM state encoding (S_IDLE, S_BUSY).
- One natural sub-module, md_compute: combinational 64-bit product and quotient/remainder producing pending_hi/pending_lo, plus the divide-by-zero flag.
- The FSM, counter, HI/LO registers and stall logic stay in md_sequencer.

Test Plan:
- Reset hold then release -> hi=0, lo=0, busy=0, md_out=0. Assert reset during BUSY of a mult -> next cycle busy=0 and hi/lo=0.
- mult p1=0xFFFFFFFE (-2), p2=3 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu, same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div p1=0xFFFFFFF9 (-7), p2=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo unchanged.
- Stall coverage: d_md_use=1 during the launch cycle and all busy cycles -> stall=1 throughout, 0 on the first IDLE cycle. d_md_use=0 -> stall=0 always.
- Cancel cases:
  - start=mult with cancel=1 -> busy stays 0, hi/lo unchanged.
  - mtlo p1=0x1234 with cancel=1 -> lo unchanged.
  - mtlo without cancel -> lo=0x1234 next cycle, busy=0.
- Issue mthi p1=0xAAAA while BUSY -> ignored; hi at commit equals the mult result. Launch immediately on the first IDLE cycle -> accepted, busy rises next cycle.
